// File: rtl/alu_exec_stage_if.sv
// Handshake and writeback bundle between the operand-read stage, the execute stage
// and the register-file write port.
interface alu_exec_stage_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              ex_valid;
    logic              ex_ready;
    logic [3:0]        ex_opcode;
    logic [ADDR_W-1:0] ex_dest;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic              ex_flush;
    logic              wb_load;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              wb_zero;
    logic              wb_carry;

    modport master (
        output ex_valid, ex_opcode, ex_dest, op1, op2, ex_flush,
        input  ex_ready, wb_load, wb_addr, wb_data, wb_zero, wb_carry
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_dest, op1, op2, ex_flush,
        output ex_ready, wb_load, wb_addr, wb_data, wb_zero, wb_carry
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier,
// returning results to the register file as a one-cycle write pulse.
module alu_exec_stage #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_stage_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              wb_load_q, wb_load_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]  wb_data_q, wb_data_d;
    logic              wb_zero_q, wb_zero_d;
    logic              wb_carry_q, wb_carry_d;

    logic [WIDTH:0]    alu_res_s;
    logic [WIDTH:0]    mul_sum_s;
    logic [WIDTH-1:0]  mul_acc_s;
    logic [WIDTH-1:0]  mul_low_s;

    // Single-cycle ops; result in [WIDTH-1:0], carry/borrow/shift-out in [WIDTH].
    function automatic logic [WIDTH:0] alu_op(
        input logic [3:0]       opc,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] r;
        logic [WIDTH:0] t;
        logic [3:0]     sh;
        r  = '0;
        t  = '0;
        sh = b[3:0];
        case (opc)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {(a < b), a - b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_NOT:  r = {1'b0, ~a};
            OP_SHL: begin
                t = {1'b0, a} << sh;
                r = t;
            end
            OP_SHR: begin
                // the extra low bit catches the last bit shifted out
                t = {a, 1'b0} >> sh;
                r = {t[0], t[WIDTH:1]};
            end
            OP_MOV:  r = {1'b0, b};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_res_s = alu_op(bus.ex_opcode, bus.op1, bus.op2);

    // One shift-add step on the {acc, mplier} product register; the adder carry
    // enters the top of the product as everything shifts right.
    assign mul_sum_s = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mul_acc_s = mul_sum_s[WIDTH:1];
    assign mul_low_s = {mul_sum_s[0], mplier_q[WIDTH-1:1]};

    assign bus.ex_ready = (state_q == ST_IDLE);
    assign bus.wb_load  = wb_load_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_zero  = wb_zero_q;
    assign bus.wb_carry = wb_carry_q;

    // Next-state and next-output logic; writeback fields only change on entry to WB.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        dest_d     = dest_q;
        wb_load_d  = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_zero_d  = wb_zero_q;
        wb_carry_d = wb_carry_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ex_flush) begin
                    state_d = ST_IDLE;
                end else if (bus.ex_valid) begin
                    case (bus.ex_opcode)
                        OP_MUL: begin
                            state_d  = ST_MUL;
                            count_d  = '0;
                            acc_d    = '0;
                            mcand_d  = bus.op1;
                            mplier_d = bus.op2;
                            dest_d   = bus.ex_dest;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_NOT, OP_SHL, OP_SHR, OP_MOV: begin
                            state_d    = ST_WB;
                            wb_load_d  = 1'b1;
                            wb_addr_d  = bus.ex_dest;
                            wb_data_d  = alu_res_s[WIDTH-1:0];
                            wb_zero_d  = (alu_res_s[WIDTH-1:0] == '0);
                            wb_carry_d = alu_res_s[WIDTH];
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (bus.ex_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = mul_acc_s;
                    mplier_d = mul_low_s;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == COUNT_LAST) begin
                        state_d    = ST_WB;
                        wb_load_d  = 1'b1;
                        wb_addr_d  = dest_q;
                        wb_data_d  = mul_low_s;
                        wb_zero_d  = (mul_low_s == '0);
                        wb_carry_d = |mul_acc_s;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            dest_q     <= '0;
            wb_load_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_zero_q  <= 1'b0;
            wb_carry_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            dest_q     <= dest_d;
            wb_load_q  <= wb_load_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_zero_q  <= wb_zero_d;
            wb_carry_q <= wb_carry_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, hand-written
// flush/reset/throughput sequences, and random ops against an arithmetic model.
module tb_alu_exec_stage;
    localparam int W  = 16;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec_stage_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
    alu_exec_stage #(.WIDTH(W), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [3:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dest;
        logic [15:0] exp_data;
        logic        exp_c;
        logic        exp_z;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, result in [15:0], carry in [16].
    function automatic logic [16:0] model(input logic [3:0] opc, input logic [15:0] a16, input logic [15:0] b16);
        longint a, b, p, res, c, sh;
        a = longint'(a16); b = longint'(b16); sh = b % 16;
        res = 0; c = 0;
        case (opc)
            4'd0: begin res = a + b; c = (res >= 65536) ? 1 : 0; end
            4'd1: begin res = a - b + 65536; c = (a < b) ? 1 : 0; end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = 65535 - a;
            4'd6: begin res = a * (longint'(1) << sh); c = (sh == 0) ? 0 : ((a >> (16 - sh)) & 1); end
            4'd7: begin res = a >> sh; c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1); end
            4'd8: begin p = a * b; res = p; c = (p >= 65536) ? 1 : 0; end
            4'd9: res = b;
            default: res = 0;
        endcase
        res = res % 65536;
        return {c[0], res[15:0]};
    endfunction

    task automatic drive(input logic v, input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
        bus.ex_valid = v; bus.ex_opcode = opc; bus.op1 = a; bus.op2 = b; bus.ex_dest = d;
    endtask

    // Issue one op from IDLE and check latency, writeback fields and return to IDLE.
    task automatic run_op(input string name, input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input logic [15:0] ed, input logic ec, input logic ez);
        int lat;
        @(negedge clk);
        check({name, " ready_before"}, bus.ex_ready, 1);
        drive(1'b1, opc, a, b, d);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        if (opc >= 4'd10) begin
            check({name, " nop_load"}, bus.wb_load, 0);
            check({name, " nop_ready"}, bus.ex_ready, 1);
        end else begin
            lat = 1;
            while (bus.wb_load !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check({name, " latency"}, lat, (opc == 4'd8) ? 17 : 1);
            check({name, " data"}, bus.wb_data, ed);
            check({name, " addr"}, bus.wb_addr, d);
            check({name, " carry"}, bus.wb_carry, ec);
            check({name, " zero"}, bus.wb_zero, ez);
            @(negedge clk);
            check({name, " load_drop"}, bus.wb_load, 0);
            check({name, " ready_after"}, bus.ex_ready, 1);
        end
    endtask

    task automatic count_loads(input string name, input int cycles, input int exp);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.wb_load === 1'b1) n++;
        end
        check(name, n, exp);
    endtask

    initial begin
        logic [16:0] e;
        logic [3:0]  ro;
        logic [15:0] ra, rb;
        int lat;

        vecs[0]  = '{4'd0, 16'd10,    16'd1000,  3'd5, 16'd1010,  1'b0, 1'b0};
        vecs[1]  = '{4'd1, 16'd100,   16'd500,   3'd1, 16'hFE70,  1'b1, 1'b0};
        vecs[2]  = '{4'd0, 16'hFFFF,  16'd1,     3'd2, 16'h0000,  1'b1, 1'b1};
        vecs[3]  = '{4'd8, 16'd100,   16'd500,   3'd3, 16'hC350,  1'b0, 1'b0};
        vecs[4]  = '{4'd8, 16'd10000, 16'd10,    3'd4, 16'h86A0,  1'b1, 1'b0};
        vecs[5]  = '{4'd6, 16'd1,     16'd15,    3'd6, 16'h8000,  1'b0, 1'b0};
        vecs[6]  = '{4'd7, 16'd3,     16'd1,     3'd7, 16'h0001,  1'b1, 1'b0};
        vecs[7]  = '{4'd12, 16'd5,    16'd6,     3'd1, 16'h0000,  1'b0, 1'b0};
        vecs[8]  = '{4'd2, 16'hF0F0,  16'h3C3C,  3'd0, 16'h3030,  1'b0, 1'b0};
        vecs[9]  = '{4'd3, 16'hF0F0,  16'h3C3C,  3'd1, 16'hFCFC,  1'b0, 1'b0};
        vecs[10] = '{4'd4, 16'hF0F0,  16'h3C3C,  3'd2, 16'hCCCC,  1'b0, 1'b0};
        vecs[11] = '{4'd5, 16'h00FF,  16'h1234,  3'd3, 16'hFF00,  1'b0, 1'b0};
        vecs[12] = '{4'd9, 16'hAAAA,  16'h1234,  3'd4, 16'h1234,  1'b0, 1'b0};
        vecs[13] = '{4'd6, 16'h8001,  16'd1,     3'd5, 16'h0002,  1'b1, 1'b0};
        vecs[14] = '{4'd7, 16'h1234,  16'hFFF0,  3'd6, 16'h1234,  1'b0, 1'b0};
        vecs[15] = '{4'd6, 16'h1234,  16'h0013,  3'd7, 16'h91A0,  1'b0, 1'b0};
        vecs[16] = '{4'd8, 16'hFFFF,  16'hFFFF,  3'd0, 16'h0001,  1'b1, 1'b0};
        vecs[17] = '{4'd8, 16'd0,     16'h1234,  3'd1, 16'h0000,  1'b0, 1'b1};

        rst_n = 1'b0;
        bus.ex_flush = 1'b0;
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0);
        repeat (2) @(negedge clk);
        check("reset ready", bus.ex_ready, 1);
        check("reset load", bus.wb_load, 0);
        check("reset data", bus.wb_data, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++)
            run_op($sformatf("vec%0d", i), vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].dest,
                   vecs[i].exp_data, vecs[i].exp_c, vecs[i].exp_z);

        // flush mid-MUL: back to IDLE after one edge, no write ever
        @(negedge clk); drive(1'b1, 4'd8, 16'd100, 16'd500, 3'd3);
        @(negedge clk); bus.ex_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.ex_flush = 1'b1;
        @(negedge clk); bus.ex_flush = 1'b0;
        check("flush_mul ready", bus.ex_ready, 1);
        check("flush_mul load", bus.wb_load, 0);
        count_loads("flush_mul no_write", 20, 0);

        // flush together with valid in IDLE: not accepted until flush drops
        @(negedge clk); drive(1'b1, 4'd0, 16'd7, 16'd8, 3'd2); bus.ex_flush = 1'b1;
        @(negedge clk);
        check("flush_idle load", bus.wb_load, 0);
        check("flush_idle ready", bus.ex_ready, 1);
        bus.ex_flush = 1'b0;
        @(negedge clk); bus.ex_valid = 1'b0;
        check("flush_idle later_load", bus.wb_load, 1);
        check("flush_idle later_data", bus.wb_data, 15);

        // flush during WB does not cancel the write
        @(negedge clk); drive(1'b1, 4'd0, 16'd9, 16'd9, 3'd4);
        @(negedge clk); bus.ex_valid = 1'b0; bus.ex_flush = 1'b1;
        check("flush_wb load", bus.wb_load, 1);
        check("flush_wb data", bus.wb_data, 18);
        @(negedge clk); bus.ex_flush = 1'b0;
        check("flush_wb ready", bus.ex_ready, 1);

        // valid while busy is ignored and operand changes do not disturb the MUL
        @(negedge clk); drive(1'b1, 4'd8, 16'd100, 16'd500, 3'd3);
        @(negedge clk); drive(1'b1, 4'd0, 16'd1, 16'd2, 3'd6);
        repeat (5) @(negedge clk);
        bus.ex_valid = 1'b0;
        lat = 6;
        while (bus.wb_load !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("busy latency", lat, 17);
        check("busy data", bus.wb_data, 16'hC350);
        check("busy addr", bus.wb_addr, 3);
        count_loads("busy no_extra", 4, 0);

        // reset mid-MUL: immediate clear, pending result discarded
        run_op("pre_rst", 4'd0, 16'd1, 16'd1, 3'd7, 16'd2, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 4'd8, 16'd100, 16'd500, 3'd3);
        @(negedge clk); bus.ex_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid ready", bus.ex_ready, 1);
        check("rst_mid load", bus.wb_load, 0);
        check("rst_mid data", bus.wb_data, 0);
        check("rst_mid addr", bus.wb_addr, 0);
        @(negedge clk); rst_n = 1'b1;
        count_loads("rst_mid no_write", 25, 0);

        // back-to-back ALU ops with valid held: one accept every 2 cycles
        @(negedge clk); drive(1'b1, 4'd0, 16'd5, 16'd6, 3'd1);
        count_loads("b2b loads", 6, 3);
        bus.ex_valid = 1'b0;
        @(negedge clk);
        check("b2b data", bus.wb_data, 11);
        check("b2b idle", bus.wb_load, 0);

        // random ops against the model
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = ((i % 4) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            e  = model(ro, ra, rb);
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 3'($urandom_range(0, 7)),
                   e[15:0], e[16], (e[15:0] == 16'd0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
